keypress_encoder: RTL and testbench

Converts USB HID keyboard reports into the per-player `keypress` bitmasks consumed by the player controllers, plus the legacy `keycode` and `press` signals. A report is latched and scanned one slot per clock. The result is staged and presented to the players only on `frame_clk` rising edges, so each player sees one stable mask per frame. The block sits between the USB keyboard interface (NIOS/HPI side) and `player1`/`player2`.

---
 rtl/game_pkg.sv | 52 +++++
 rtl/frame_edge_det.sv | 21 ++
 rtl/keypress_encoder.sv | 147 ++++++++++++++
 tb/tb_keypress_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-side definitions: keypress bit layout, HID error codes,
// encoder FSM states and the keycode-to-player mapping helper.
package game_pkg;

   localparam int KP_PUNCH = 0;
   localparam int KP_RIGHT = 1;
   localparam int KP_LEFT  = 2;
   localparam int KP_JUMP  = 3;

   localparam logic [7:0] HID_ERR_ROLLOVER = 8'h01;
   localparam logic [7:0] HID_POST_FAIL    = 8'h02;
   localparam logic [7:0] HID_ERR_UNDEF    = 8'h03;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} kenc_state_t;

   typedef struct packed {
      logic       player;   // 0 = player 1, 1 = player 2
      logic [1:0] bit_idx;
      logic       valid;
   } key_map_t;

   // keymap entry j describes player j[2], keypress bit j[1:0]
   function automatic key_map_t map_key(input logic [7:0] kc,
                                        input logic [7:0][7:0] keymap);
      key_map_t r;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         if (kc != 8'h00 && kc == keymap[j]) begin
            r.valid   = 1'b1;
            r.player  = j[2];
            r.bit_idx = j[1:0];
         end
      end
      return r;
   endfunction

   function automatic logic is_hid_err(input logic [7:0] kc);
      return (kc == HID_ERR_ROLLOVER) || (kc == HID_POST_FAIL) || (kc == HID_ERR_UNDEF);
   endfunction

   // Opposing directions cancel out rather than favouring one side.
   function automatic logic [3:0] resolve_lr(input logic [3:0] m);
      logic [3:0] r;
      r = m;
      if (m[KP_LEFT] && m[KP_RIGHT]) begin
         r[KP_LEFT]  = 1'b0;
         r[KP_RIGHT] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Frame-clock rising-edge detector: one delay flop and a registered pulse.
module frame_edge_det (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic fe
);

   logic fc_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fc_d <= 1'b0;
         fe   <= 1'b0;
      end else begin
         fc_d <= frame_clk;
         fe   <= frame_clk & ~fc_d;
      end
   end

endmodule

// File: rtl/keypress_encoder.sv
// HID keyboard report to per-player keypress masks; scans one slot per clock
// and presents results to the players only on frame edges.
module keypress_encoder
   import game_pkg::*;
#(
   parameter int         NUM_SLOTS   = 6,
   parameter logic [7:0] KC_P1_LEFT  = 8'h04,
   parameter logic [7:0] KC_P1_RIGHT = 8'h07,
   parameter logic [7:0] KC_P1_PUNCH = 8'h16,
   parameter logic [7:0] KC_P1_JUMP  = 8'h1A,
   parameter logic [7:0] KC_P2_LEFT  = 8'h50,
   parameter logic [7:0] KC_P2_RIGHT = 8'h4F,
   parameter logic [7:0] KC_P2_PUNCH = 8'h51,
   parameter logic [7:0] KC_P2_JUMP  = 8'h52
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   input  logic                   report_valid,
   input  logic [8*NUM_SLOTS-1:0] report_keys,
   output logic [7:0]             keypress1,
   output logic [7:0]             keypress2,
   output logic [7:0]             keycode,
   output logic                   press,
   output logic                   busy
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
   localparam logic [7:0][7:0] KEYMAP = {KC_P2_JUMP, KC_P2_LEFT, KC_P2_RIGHT, KC_P2_PUNCH,
                                         KC_P1_JUMP, KC_P1_LEFT, KC_P1_RIGHT, KC_P1_PUNCH};

   kenc_state_t                 state, state_nx;
   logic [IDX_W-1:0]            idx;
   logic [NUM_SLOTS-1:0][7:0]   rpt_q, pend;
   logic                        pend_v;
   logic [3:0]                  acc1, acc2, stg1, stg2;
   logic [7:0]                  acc_kc, stg_kc;
   logic                        err;
   logic                        fe;

   logic [7:0]                  slot;
   key_map_t                    km;
   logic [3:0]                  hit;

   frame_edge_det u_fe (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .fe        (fe)
   );

   assign slot = rpt_q[idx];
   assign km   = map_key(slot, KEYMAP);
   assign hit  = 4'b0001 << km.bit_idx;
   assign busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (report_valid) state_nx = SCAN;
         SCAN:    if (idx == LAST_IDX) state_nx = COMMIT;
         COMMIT:  state_nx = (report_valid || pend_v) ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx    <= '0;
         rpt_q  <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
         acc1   <= '0;
         acc2   <= '0;
         acc_kc <= '0;
         err    <= 1'b0;
         stg1   <= '0;
         stg2   <= '0;
         stg_kc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (report_valid) begin
                  rpt_q  <= report_keys;
                  idx    <= '0;
                  acc1   <= '0;
                  acc2   <= '0;
                  acc_kc <= '0;
                  err    <= 1'b0;
               end
            end
            SCAN: begin
               if (report_valid) begin
                  pend   <= report_keys;
                  pend_v <= 1'b1;
               end
               idx <= idx + 1'b1;
               if (is_hid_err(slot)) begin
                  err <= 1'b1;
               end else if (slot != 8'h00) begin
                  if (km.valid && !km.player) acc1 <= acc1 | hit;
                  if (km.valid &&  km.player) acc2 <= acc2 | hit;
                  if (acc_kc == 8'h00) acc_kc <= slot;
               end
            end
            COMMIT: begin
               if (!err) begin
                  stg1   <= resolve_lr(acc1);
                  stg2   <= resolve_lr(acc2);
                  stg_kc <= acc_kc;
               end
               // A report arriving right now is newer than anything pending.
               if (report_valid)  rpt_q <= report_keys;
               else if (pend_v)   rpt_q <= pend;
               pend_v <= 1'b0;
               idx    <= '0;
               acc1   <= '0;
               acc2   <= '0;
               acc_kc <= '0;
               err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         keypress1 <= '0;
         keypress2 <= '0;
         keycode   <= '0;
         press     <= 1'b0;
      end else if (fe) begin
         keypress1 <= {4'b0000, stg1};
         keypress2 <= {4'b0000, stg2};
         keycode   <= stg_kc;
         press     <= (|stg1) | (|stg2);
      end
   end

endmodule

// File: tb/tb_keypress_encoder.sv
// Directed bench for keypress_encoder: one task per scenario, inline checks.
module tb_keypress_encoder;

   localparam int NS = 6;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          frame_clk = 1'b0;
   logic          report_valid = 1'b0;
   logic [8*NS-1:0] report_keys = '0;
   logic [7:0]    keypress1, keypress2, keycode;
   logic          press, busy;

   int n_checks = 0;
   int n_fail   = 0;

   keypress_encoder #(.NUM_SLOTS(NS)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .report_valid (report_valid),
      .report_keys  (report_keys),
      .keypress1    (keypress1),
      .keypress2    (keypress2),
      .keycode      (keycode),
      .press        (press),
      .busy         (busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [8*NS-1:0] mk(input logic [7:0] s0, s1, s2, s3, s4, s5);
      return {s5, s4, s3, s2, s1, s0};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Pulse report_valid for one cycle, then wait until the commit has landed.
   task automatic send(input logic [8*NS-1:0] keys);
      report_valid = 1'b1;
      report_keys  = keys;
      tick();
      report_valid = 1'b0;
      report_keys  = '0;
      repeat (NS + 1) tick();
   endtask

   // Full frame: fe rises after the first edge, outputs load on the second.
   task automatic frame();
      frame_clk = 1'b1;
      tick();
      tick();
      frame_clk = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) tick();
      Reset = 1'b0;
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL reset_kp1 got %h exp 00", keypress1); end
      n_checks++; if (keypress2 !== 8'h00) begin n_fail++; $display("FAIL reset_kp2 got %h exp 00", keypress2); end
      n_checks++; if (keycode !== 8'h00) begin n_fail++; $display("FAIL reset_kc got %h exp 00", keycode); end
      n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL reset_press got %b exp 0", press); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_single();
      report_valid = 1'b1;
      report_keys  = mk(8'h04, 0, 0, 0, 0, 0);
      tick();
      report_valid = 1'b0;
      report_keys  = '0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_scan got %b exp 1", busy); end
      repeat (NS) tick();
      // COMMIT cycle
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_commit got %b exp 1", busy); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle got %b exp 0", busy); end
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL single_kp1_prefe got %h exp 00", keypress1); end
      frame_clk = 1'b1;
      tick();
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL single_kp1_fe got %h exp 00", keypress1); end
      tick();
      frame_clk = 1'b0;
      n_checks++; if (keypress1 !== 8'h04) begin n_fail++; $display("FAIL single_kp1 got %h exp 04", keypress1); end
      n_checks++; if (keypress2 !== 8'h00) begin n_fail++; $display("FAIL single_kp2 got %h exp 00", keypress2); end
      n_checks++; if (keycode !== 8'h04) begin n_fail++; $display("FAIL single_kc got %h exp 04", keycode); end
      n_checks++; if (press !== 1'b1) begin n_fail++; $display("FAIL single_press got %b exp 1", press); end
      tick();
   endtask

   task automatic test_multi();
      send(mk(8'h07, 8'h50, 8'h16, 0, 0, 0));
      repeat (3) tick();
      n_checks++; if (keypress1 !== 8'h04) begin n_fail++; $display("FAIL multi_hold_kp1 got %h exp 04", keypress1); end
      frame();
      n_checks++; if (keypress1 !== 8'h03) begin n_fail++; $display("FAIL multi_kp1 got %h exp 03", keypress1); end
      n_checks++; if (keypress2 !== 8'h04) begin n_fail++; $display("FAIL multi_kp2 got %h exp 04", keypress2); end
      n_checks++; if (keycode !== 8'h07) begin n_fail++; $display("FAIL multi_kc got %h exp 07", keycode); end
      n_checks++; if (press !== 1'b1) begin n_fail++; $display("FAIL multi_press got %b exp 1", press); end
   endtask

   task automatic test_conflict();
      send(mk(8'h04, 8'h07, 0, 0, 0, 0));
      frame();
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL conflict_kp1 got %h exp 00", keypress1); end
      n_checks++; if (keycode !== 8'h04) begin n_fail++; $display("FAIL conflict_kc got %h exp 04", keycode); end
      n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL conflict_press got %b exp 0", press); end
   endtask

   task automatic test_error();
      send(mk(8'h07, 0, 0, 0, 0, 0));
      frame();
      n_checks++; if (keypress1 !== 8'h02) begin n_fail++; $display("FAIL err_prior_kp1 got %h exp 02", keypress1); end
      send(mk(8'h04, 0, 0, 8'h01, 0, 0));
      for (int f = 0; f < 2; f++) begin
         frame();
         n_checks++; if (keypress1 !== 8'h02) begin n_fail++; $display("FAIL err_kp1 frame%0d got %h exp 02", f, keypress1); end
         n_checks++; if (keycode !== 8'h07) begin n_fail++; $display("FAIL err_kc frame%0d got %h exp 07", f, keycode); end
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      int guard;
      cnt = 0;
      guard = 0;
      report_valid = 1'b1;
      report_keys  = mk(8'h04, 0, 0, 0, 0, 0);
      tick();
      if (busy) cnt++;
      report_keys  = mk(8'h07, 0, 0, 0, 0, 0);
      tick();
      if (busy) cnt++;
      report_keys  = '0;
      tick();
      report_valid = 1'b0;
      while (busy && guard < 40) begin
         cnt++;
         guard++;
         tick();
      end
      n_checks++; if (cnt !== 2 * (NS + 1)) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d exp %0d", cnt, 2 * (NS + 1)); end
      frame();
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL b2b_kp1 got %h exp 00", keypress1); end
      n_checks++; if (keycode !== 8'h00) begin n_fail++; $display("FAIL b2b_kc got %h exp 00", keycode); end
      n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL b2b_press got %b exp 0", press); end
   endtask

   // fe lands in the COMMIT cycle: old staged value wins this frame.
   task automatic test_frame_commit();
      report_valid = 1'b1;
      report_keys  = mk(8'h04, 0, 0, 0, 0, 0);
      tick();
      report_valid = 1'b0;
      report_keys  = '0;
      repeat (NS - 1) tick();
      frame_clk = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fc_commit_busy got %b exp 1", busy); end
      tick();
      frame_clk = 1'b0;
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL fc_kp1_old got %h exp 00", keypress1); end
      tick();
      frame();
      n_checks++; if (keypress1 !== 8'h04) begin n_fail++; $display("FAIL fc_kp1_new got %h exp 04", keypress1); end
   endtask

   task automatic test_reset_mid_scan();
      report_valid = 1'b1;
      report_keys  = mk(8'h16, 0, 0, 0, 0, 0);
      tick();
      report_valid = 1'b0;
      report_keys  = '0;
      repeat (2) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rms_busy got %b exp 0", busy); end
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL rms_kp1_rst got %h exp 00", keypress1); end
      repeat (10) tick();
      frame();
      n_checks++; if (keypress1 !== 8'h00) begin n_fail++; $display("FAIL rms_kp1 got %h exp 00", keypress1); end
      n_checks++; if (keycode !== 8'h00) begin n_fail++; $display("FAIL rms_kc got %h exp 00", keycode); end
      n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL rms_press got %b exp 0", press); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rms_busy_end got %b exp 0", busy); end
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_multi();
      test_conflict();
      test_error();
      test_back_to_back();
      test_frame_commit();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
